// File: rtl/gaussian_filter_pipe.sv
// Three-stage multi-lane Gaussian smoothing stage (bypass / 3x3 / 5x5) with valid/ready backpressure.
// S1 forms weighted row sums per lane, S2 combines rows, S3 rounds, clamps and registers the output.
module gaussian_filter_pipe #(
  parameter int LANES = 8,
  parameter int PIX_W = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [1:0]                     in_mode,
  input  logic                           in_last,
  input  logic [5*(LANES+4)*PIX_W-1:0]   win_i,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic [LANES*PIX_W-1:0]         pix_o
);

  localparam int NC    = LANES + 4;
  localparam int ACC_W = PIX_W + 9;
  localparam logic [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_W) - 1);

  typedef enum logic [1:0] {
    MODE_BYP = 2'b00,
    MODE_G3  = 2'b01,
    MODE_G5  = 2'b10
  } mode_e;

  logic       en;
  mode_e      mode_in;
  logic       s1_valid, s2_valid, s1_last, s2_last;
  mode_e      s1_mode, s2_mode;

  logic [ACC_W-1:0]       h_nxt [5][LANES];
  logic [ACC_W-1:0]       s1_h  [5][LANES];
  logic [ACC_W-1:0]       v_nxt [LANES];
  logic [ACC_W-1:0]       s2_v  [LANES];
  logic [LANES*PIX_W-1:0] pix_nxt;

  // Whole pipe moves in lock-step; a stalled output freezes every stage.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  always_comb begin
    unique case (in_mode)
      2'b00:   mode_in = MODE_BYP;
      2'b01:   mode_in = MODE_G3;
      default: mode_in = MODE_G5;
    endcase
  end

  // S1: horizontal pass. Rows a mode does not use are zeroed so S2 stays uniform.
  always_comb begin
    logic [ACC_W-1:0] a0, a1, a2, a3, a4;
    // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
    a0 = '0; a1 = '0; a2 = '0; a3 = '0; a4 = '0;
    for (int r = 0; r < 5; r++) begin
      for (int p = 0; p < LANES; p++) begin
        a0 = ACC_W'(win_i[(r*NC + p    )*PIX_W +: PIX_W]);
        a1 = ACC_W'(win_i[(r*NC + p + 1)*PIX_W +: PIX_W]);
        a2 = ACC_W'(win_i[(r*NC + p + 2)*PIX_W +: PIX_W]);
        a3 = ACC_W'(win_i[(r*NC + p + 3)*PIX_W +: PIX_W]);
        a4 = ACC_W'(win_i[(r*NC + p + 4)*PIX_W +: PIX_W]);
        h_nxt[r][p] = '0;
        unique case (mode_in)
          MODE_BYP: if (r == 2) h_nxt[r][p] = a2;
          MODE_G3:  if (r >= 1 && r <= 3) h_nxt[r][p] = a1 + (a2 << 1) + a3;
          default:  h_nxt[r][p] = a0 + (a1 << 2) + (a2 << 2) + (a2 << 1) + (a3 << 2) + a4;
        endcase
      end
    end
  end

  // S2: vertical pass with the same 1-D kernel, giving the exact 2-D outer-product sum.
  always_comb begin
    for (int p = 0; p < LANES; p++) begin
      v_nxt[p] = '0;
      unique case (s1_mode)
        MODE_BYP: v_nxt[p] = s1_h[2][p];
        MODE_G3:  v_nxt[p] = s1_h[1][p] + (s1_h[2][p] << 1) + s1_h[3][p];
        default:  v_nxt[p] = s1_h[0][p] + (s1_h[1][p] << 2) + (s1_h[2][p] << 2)
                           + (s1_h[2][p] << 1) + (s1_h[3][p] << 2) + s1_h[4][p];
      endcase
    end
  end

  // S3: round-to-nearest normalisation and saturation.
  always_comb begin
    logic [ACC_W-1:0] rnd;
    rnd     = '0;
    pix_nxt = '0;
    for (int p = 0; p < LANES; p++) begin
      unique case (s2_mode)
        MODE_BYP: rnd = s2_v[p];
        MODE_G3:  rnd = (s2_v[p] + ACC_W'(8)) >> 4;
        default:  rnd = (s2_v[p] + ACC_W'(128)) >> 8;
      endcase
      pix_nxt[p*PIX_W +: PIX_W] = (rnd > PIX_MAX) ? {PIX_W{1'b1}} : rnd[PIX_W-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_mode   <= MODE_BYP;
      s1_last   <= 1'b0;
      s2_valid  <= 1'b0;
      s2_mode   <= MODE_BYP;
      s2_last   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      pix_o     <= '0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s1_mode   <= mode_in;
      s1_last   <= in_last;
      s2_valid  <= s1_valid;
      s2_mode   <= s1_mode;
      s2_last   <= s1_last;
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_last <= s2_last;
        pix_o    <= pix_nxt;
      end
    end
  end

  // NOTE: the wide datapath arrays carry no reset; the valid flags alone decide what is ever observed.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_h <= h_nxt;
      s2_v <= v_nxt;
    end
  end

endmodule

// File: tb/tb_gaussian_filter_pipe.sv
// Self-checking bench for gaussian_filter_pipe: directed scenarios plus random windows,
// scored against a direct 2-D kernel-sum reference model.
module tb_gaussian_filter_pipe;

  localparam int L     = 8;
  localparam int PW    = 8;
  localparam int NC    = L + 4;
  localparam int WIN_W = 5 * NC * PW;
  localparam int OUT_W = L * PW;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic             in_last;
  logic [WIN_W-1:0] win_i;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [OUT_W-1:0] pix_o;

  gaussian_filter_pipe #(.LANES(L), .PIX_W(PW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_last   (in_last),
    .win_i     (win_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .pix_o     (pix_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] pix;
    logic             last;
  } exp_t;

  exp_t             exp_q[$];
  int               n_vec  = 0;
  int               n_fail = 0;
  int               n_out  = 0;
  logic             stall_prev = 1'b0;
  logic             saw_backpressure = 1'b0;
  logic [OUT_W-1:0] prev_pix;
  logic             prev_last;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_vec++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic int px(input logic [WIN_W-1:0] w, input int r, input int c);
    return int'(w[(r*NC + c)*PW +: PW]);
  endfunction

  // Reference: direct 2-D sum of the outer-product kernel, rounded and clamped.
  function automatic logic [OUT_W-1:0] model(input logic [WIN_W-1:0] w, input logic [1:0] m);
    int k3[3] = '{1, 2, 1};
    int k5[5] = '{1, 4, 6, 4, 1};
    int sum, res;
    logic [OUT_W-1:0] o;
    o = '0;
    for (int p = 0; p < L; p++) begin
      sum = 0;
      if (m == 2'b00) begin
        res = px(w, 2, p + 2);
      end else if (m == 2'b01) begin
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            sum += k3[dr] * k3[dc] * px(w, 1 + dr, p + 1 + dc);
        res = (sum + 8) >> 4;
      end else begin
        for (int dr = 0; dr < 5; dr++)
          for (int dc = 0; dc < 5; dc++)
            sum += k5[dr] * k5[dc] * px(w, dr, p + dc);
        res = (sum + 128) >> 8;
      end
      if (res > (1 << PW) - 1) res = (1 << PW) - 1;
      o[p*PW +: PW] = res[PW-1:0];
    end
    return o;
  endfunction

  function automatic logic [WIN_W-1:0] rand_win();
    logic [WIN_W-1:0] w;
    for (int i = 0; i < 5 * NC; i++) w[i*PW +: PW] = PW'($urandom_range(0, (1 << PW) - 1));
    return w;
  endfunction

  function automatic logic [WIN_W-1:0] flat_win(input int v);
    logic [WIN_W-1:0] w;
    for (int i = 0; i < 5 * NC; i++) w[i*PW +: PW] = PW'(v);
    return w;
  endfunction

  // Scoreboard and stall monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (stall_prev) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_pix", 64'(pix_o), 64'(prev_pix));
        check("hold_last", 64'(out_last), 64'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_output", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_pix", 64'(pix_o), 64'(e.pix));
          check("out_last", 64'(out_last), 64'(e.last));
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        e.pix  = model(win_i, in_mode);
        e.last = in_last;
        exp_q.push_back(e);
      end
      if (out_valid && !out_ready && !in_ready) saw_backpressure = 1'b1;
      stall_prev = out_valid && !out_ready;
      prev_pix   = pix_o;
      prev_last  = out_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Presents one beat and returns just after its accepting edge.
  task automatic drive(input logic [WIN_W-1:0] w, input logic [1:0] m, input logic l);
    int guard = 0;
    win_i    = w;
    in_mode  = m;
    in_last  = l;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  // One isolated beat; latency counts clock edges including the accepting one.
  task automatic send_single(input logic [WIN_W-1:0] w, input logic [1:0] m,
                             input string tag, output logic [OUT_W-1:0] got);
    int edges;
    drive(w, m, 1'b0);
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check({tag, "_latency"}, 64'(edges), 64'd3);
    got = pix_o;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIN_W-1:0] imp;
    logic [OUT_W-1:0] got, g5;
    int               base;

    imp = '0;
    imp[(2*NC + 2)*PW +: PW] = 8'd255;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 2'b00;
    in_last   = 1'b0;
    win_i     = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_pix", 64'(pix_o), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int m = 0; m < 4; m++) begin
      send_single(flat_win(100), 2'(m), "flat", got);
      check("flat_value", 64'(got), {8{8'd100}});
    end

    send_single(imp, 2'b10, "imp5", g5);
    check("imp5_value", 64'(g5), 64'h0000_0000_0006_1824);
    send_single(imp, 2'b01, "imp3", got);
    check("imp3_lane0", 64'(got[7:0]), 64'd64);
    send_single(imp, 2'b00, "impb", got);
    check("impb_value", 64'(got), 64'h0000_0000_0000_00ff);
    send_single(imp, 2'b11, "imp11", got);
    check("imp11_value", 64'(got), 64'h0000_0000_0006_1824);

    // Continuous random stream with a 5-cycle downstream stall mid-way.
    base = n_out;
    saw_backpressure = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++)
          drive(rand_win(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        in_valid = 1'b0;
      end
      begin
        repeat (8) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("stall_beats", 64'(n_out - base), 64'd20);
    check("stall_backpressure", 64'(saw_backpressure), 64'd1);

    // Mode changes per beat on the impulse window, in_last on every 4th beat.
    base = n_out;
    for (int i = 0; i < 12; i++)
      drive(imp, (i % 3 == 0) ? 2'b01 : (i % 3 == 1) ? 2'b10 : 2'b00, (i % 4 == 3));
    in_valid = 1'b0;
    drain();
    check("alt_beats", 64'(n_out - base), 64'd12);

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) drive(rand_win(), 2'($urandom_range(0, 3)), 1'b1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_pix", 64'(pix_o), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    base = n_out;
    send_single(rand_win(), 2'b10, "postrst", got);
    drain();
    check("postrst_beats", 64'(n_out - base), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
